// File: rtl/alu_issue_stage_pkg.sv
// Shared CPU definitions: default datapath widths and ALU opcode encodings.
package alu_issue_stage_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultRegw  = 5;

  localparam logic [4:0] AluAdd = 5'b00000;
  localparam logic [4:0] AluSub = 5'b00001;
  localparam logic [4:0] AluAnd = 5'b00010;
  localparam logic [4:0] AluOr  = 5'b00011;
  localparam logic [4:0] AluSll = 5'b00100;
  localparam logic [4:0] AluSra = 5'b00101;

endpackage

// File: rtl/alu_issue_stage_bypass.sv
// Operand bypass select: XM beats MW, register 0 is never forwarded.
module bypass_mux
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned REGW  = DefaultRegw
) (
  input  logic [REGW-1:0]  addr,
  input  logic [WIDTH-1:0] rf_data,
  input  logic             xm_we,
  input  logic [REGW-1:0]  xm_rd,
  input  logic [WIDTH-1:0] xm_data,
  input  logic             mw_we,
  input  logic [REGW-1:0]  mw_rd,
  input  logic [WIDTH-1:0] mw_data,
  output logic [WIDTH-1:0] data
);

  logic addr_nz;
  assign addr_nz = (addr != '0);

  always_comb begin
    data = rf_data;
    if (xm_we && (xm_rd == addr) && addr_nz) begin
      data = xm_data;
    end else if (mw_we && (mw_rd == addr) && addr_nz) begin
      data = mw_data;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Two-entry issue skid buffer between decode and the ALU, forwarding operands on
// capture and refreshing held entries from the XM/MW bypass buses every cycle.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned REGW  = DefaultRegw
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REGW-1:0]  in_aluop,
  input  logic [REGW-1:0]  in_shamt,
  input  logic [REGW-1:0]  in_rs_addr,
  input  logic [REGW-1:0]  in_rt_addr,
  input  logic [WIDTH-1:0] in_rs_data,
  input  logic [WIDTH-1:0] in_rt_data,
  input  logic             in_imm_sel,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             xm_we,
  input  logic [REGW-1:0]  xm_rd,
  input  logic [WIDTH-1:0] xm_data,
  input  logic             mw_we,
  input  logic [REGW-1:0]  mw_rd,
  input  logic [WIDTH-1:0] mw_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_operandA,
  output logic [WIDTH-1:0] out_operandB,
  output logic [REGW-1:0]  out_aluop,
  output logic [REGW-1:0]  out_shamt
);

  logic [1:0] cnt_q, cnt_d;
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic       rdy_q;
  logic       accept, pop;

  logic [REGW-1:0]  aluop_q   [2];
  logic [REGW-1:0]  shamt_q   [2];
  logic [REGW-1:0]  rs_addr_q [2];
  logic [REGW-1:0]  rt_addr_q [2];
  logic             imm_sel_q [2];
  logic [WIDTH-1:0] a_q       [2];
  logic [WIDTH-1:0] b_q       [2];
  logic [WIDTH-1:0] imm_q     [2];

  logic [REGW-1:0]  aluop_d   [2];
  logic [REGW-1:0]  shamt_d   [2];
  logic [REGW-1:0]  rs_addr_d [2];
  logic [REGW-1:0]  rt_addr_d [2];
  logic             imm_sel_d [2];
  logic [WIDTH-1:0] a_d       [2];
  logic [WIDTH-1:0] b_d       [2];
  logic [WIDTH-1:0] imm_d     [2];

  logic [WIDTH-1:0] a_ref [2];
  logic [WIDTH-1:0] b_ref [2];
  logic [WIDTH-1:0] cap_a, cap_b;

  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready  = rdy_q && (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  bypass_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_cap_a (
    .addr(in_rs_addr), .rf_data(in_rs_data),
    .xm_we(xm_we), .xm_rd(xm_rd), .xm_data(xm_data),
    .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
    .data(cap_a)
  );

  bypass_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_cap_b (
    .addr(in_rt_addr), .rf_data(in_rt_data),
    .xm_we(xm_we), .xm_rd(xm_rd), .xm_data(xm_data),
    .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
    .data(cap_b)
  );

  for (genvar g = 0; g < 2; g++) begin : g_entry
    bypass_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_ref_a (
      .addr(rs_addr_q[g]), .rf_data(a_q[g]),
      .xm_we(xm_we), .xm_rd(xm_rd), .xm_data(xm_data),
      .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
      .data(a_ref[g])
    );

    bypass_mux #(.WIDTH(WIDTH), .REGW(REGW)) u_ref_b (
      .addr(rt_addr_q[g]), .rf_data(b_q[g]),
      .xm_we(xm_we), .xm_rd(xm_rd), .xm_data(xm_data),
      .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
      .data(b_ref[g])
    );
  end

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      cnt_d  = 2'd0;
      head_d = 1'b0;
      tail_d = 1'b0;
    end else begin
      if (accept) tail_d = ~tail_q;
      if (pop)    head_d = ~head_q;
      unique case ({accept, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Every slot tracks the bypass buses; the slot being written takes decode data instead.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      aluop_d[i]   = aluop_q[i];
      shamt_d[i]   = shamt_q[i];
      rs_addr_d[i] = rs_addr_q[i];
      rt_addr_d[i] = rt_addr_q[i];
      imm_sel_d[i] = imm_sel_q[i];
      imm_d[i]     = imm_q[i];
      a_d[i]       = a_ref[i];
      b_d[i]       = b_ref[i];
      if (accept && (int'(tail_q) == i)) begin
        aluop_d[i]   = in_aluop;
        shamt_d[i]   = in_shamt;
        rs_addr_d[i] = in_rs_addr;
        rt_addr_d[i] = in_rt_addr;
        imm_sel_d[i] = in_imm_sel;
        imm_d[i]     = in_imm;
        a_d[i]       = cap_a;
        b_d[i]       = cap_b;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      rdy_q  <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        aluop_q[i]   <= '0;
        shamt_q[i]   <= '0;
        rs_addr_q[i] <= '0;
        rt_addr_q[i] <= '0;
        imm_sel_q[i] <= 1'b0;
        imm_q[i]     <= '0;
        a_q[i]       <= '0;
        b_q[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        aluop_q[i]   <= aluop_d[i];
        shamt_q[i]   <= shamt_d[i];
        rs_addr_q[i] <= rs_addr_d[i];
        rt_addr_q[i] <= rt_addr_d[i];
        imm_sel_q[i] <= imm_sel_d[i];
        imm_q[i]     <= imm_d[i];
        a_q[i]       <= a_d[i];
        b_q[i]       <= b_d[i];
      end
    end
  end

  assign out_operandA = a_q[head_q];
  assign out_operandB = imm_sel_q[head_q] ? imm_q[head_q] : b_q[head_q];
  assign out_aluop    = aluop_q[head_q];
  assign out_shamt    = shamt_q[head_q];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: pass-through, fill/drain, forwarding, refresh,
// flush and asynchronous reset.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_aluop, in_shamt, in_rs_addr, in_rt_addr;
  logic [31:0] in_rs_data, in_rt_data, in_imm;
  logic        in_imm_sel;
  logic        xm_we, mw_we;
  logic [4:0]  xm_rd, mw_rd;
  logic [31:0] xm_data, mw_data;
  logic        out_valid, out_ready;
  logic [31:0] out_operandA, out_operandB;
  logic [4:0]  out_aluop, out_shamt;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  alu_issue_stage #(.WIDTH(32), .REGW(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_shamt(in_shamt),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .xm_we(xm_we), .xm_rd(xm_rd), .xm_data(xm_data),
    .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operandA(out_operandA), .out_operandB(out_operandB),
    .out_aluop(out_aluop), .out_shamt(out_shamt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] sh,
                       input logic [4:0] rs, input logic [31:0] rsd,
                       input logic [4:0] rt, input logic [31:0] rtd,
                       input logic isel, input logic [31:0] imm);
    in_valid   = 1'b1;
    in_aluop   = op;
    in_shamt   = sh;
    in_rs_addr = rs;
    in_rs_data = rsd;
    in_rt_addr = rt;
    in_rt_data = rtd;
    in_imm_sel = isel;
    in_imm     = imm;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_aluop = '0; in_shamt = '0; in_rs_addr = '0; in_rt_addr = '0;
    in_rs_data = '0; in_rt_data = '0; in_imm_sel = 1'b0; in_imm = '0;
    xm_we = 1'b0; xm_rd = '0; xm_data = '0;
    mw_we = 1'b0; mw_rd = '0; mw_data = '0;
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_opA", out_operandA, 0);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("pre_edge_in_ready", in_ready, 0);
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    // Pass-through
    out_ready = 1'b1;
    drive(AluAdd, 5'd0, 5'd5, 32'd7, 5'd6, 32'd9, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("pt_valid", out_valid, 1);
    chk("pt_opA", out_operandA, 32'd7);
    chk("pt_opB", out_operandB, 32'd9);
    chk("pt_aluop", out_aluop, AluAdd);
    tick();
    chk("pt_drained", out_valid, 0);

    // Fill and stall, then in-order drain
    out_ready = 1'b0;
    drive(AluSub, 5'd3, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 32'd0);
    tick();
    chk("fill1_in_ready", in_ready, 1);
    drive(AluAnd, 5'd4, 5'd7, 32'h33, 5'd8, 32'h44, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    chk("full_head_opA", out_operandA, 32'h11);
    chk("full_head_shamt", out_shamt, 5'd3);
    tick();
    chk("stall_hold_opA", out_operandA, 32'h11);
    chk("stall_hold_aluop", out_aluop, AluSub);
    out_ready = 1'b1;
    tick();
    chk("drain2_valid", out_valid, 1);
    chk("drain2_opA", out_operandA, 32'h33);
    chk("drain2_opB", out_operandB, 32'h44);
    chk("drain2_aluop", out_aluop, AluAnd);
    tick();
    chk("drain_empty", out_valid, 0);

    // Forwarding priority and register-0 exclusion
    out_ready = 1'b0;
    drive(AluOr, 5'd0, 5'd3, 32'h1234, 5'd9, 32'd5, 1'b0, 32'd0);
    xm_we = 1'b1; xm_rd = 5'd3; xm_data = 32'hAAAA;
    mw_we = 1'b1; mw_rd = 5'd3; mw_data = 32'hBBBB;
    tick();
    in_valid = 1'b0; xm_we = 1'b0; mw_we = 1'b0;
    chk("fwd_xm_prio", out_operandA, 32'hAAAA);
    chk("fwd_no_match_B", out_operandB, 32'd5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drive(AluAdd, 5'd0, 5'd0, 32'h77, 5'd0, 32'h66, 1'b0, 32'd0);
    xm_we = 1'b1; xm_rd = 5'd0; xm_data = 32'hDEAD;
    mw_we = 1'b1; mw_rd = 5'd0; mw_data = 32'hBEEF;
    tick();
    in_valid = 1'b0;
    chk("fwd_r0_A", out_operandA, 32'h77);
    chk("fwd_r0_B", out_operandB, 32'h66);
    out_ready = 1'b1;
    xm_rd = 5'd5; mw_rd = 5'd4; mw_data = 32'hBBBB;
    tick();
    out_ready = 1'b0;
    drive(AluSll, 5'd2, 5'd4, 32'd1, 5'd6, 32'd2, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0; xm_we = 1'b0; mw_we = 1'b0;
    chk("fwd_mw_only", out_operandA, 32'hBBBB);
    out_ready = 1'b1;
    tick();
    chk("fwd_drained", out_valid, 0);

    // Refresh while stalled; immediate is untouched
    out_ready = 1'b0;
    drive(AluAdd, 5'd0, 5'd2, 32'h20, 5'd4, 32'h10, 1'b0, 32'd0);
    tick();
    drive(AluSra, 5'd1, 5'd2, 32'h20, 5'd4, 32'h10, 1'b1, 32'h99);
    tick();
    in_valid = 1'b0;
    chk("ref_before", out_operandB, 32'h10);
    mw_we = 1'b1; mw_rd = 5'd4; mw_data = 32'h55;
    tick();
    mw_we = 1'b0;
    chk("ref_opB", out_operandB, 32'h55);
    chk("ref_opA_same", out_operandA, 32'h20);
    out_ready = 1'b1;
    tick();
    chk("ref_imm_kept", out_operandB, 32'h99);
    chk("ref_imm_aluop", out_aluop, AluSra);
    tick();
    chk("ref_drained", out_valid, 0);

    // Flush beats a simultaneous accept at count 1
    out_ready = 1'b0;
    drive(AluAdd, 5'd0, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'd0);
    tick();
    chk("flush_pre_valid", out_valid, 1);
    drive(AluSub, 5'd0, 5'd1, 32'h3, 5'd2, 32'h4, 1'b0, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    tick();
    chk("flush_still_empty", out_valid, 0);

    // Asynchronous reset mid-stall
    drive(AluAnd, 5'd0, 5'd1, 32'h5, 5'd2, 32'h6, 1'b0, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("ar_pre_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_opA", out_operandA, 0);
    #1 reset = 1'b1;
    tick();
    chk("ar_rel_in_ready", in_ready, 1);
    chk("ar_rel_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
